ifu_fetch_ctl_param: RTL and testbench



---
 rtl/ifu_fetch_ctl_param.sv | 182 ++++++++++++++++++
 tb/tb_ifu_fetch_ctl_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctl_param.sv
// Fetch-pipe controller: F1/F2 request sequencing, credit-based fetch-buffer
// flow control, miss replay and a halt/resume handshake that drains F2 first.
module ifu_fetch_ctl_param #(
  parameter int unsigned FETCH_BYTES = 8,
  parameter int unsigned FB_DEPTH    = 4,
  parameter int unsigned CNT_W       = $clog2(FB_DEPTH + 1),
  parameter logic [31:0] RESET_VEC   = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_valid,
  input  logic [31:1]      flush_pc,
  input  logic             flush_noredir,
  input  logic             bp_redirect_f2,
  input  logic [31:1]      bp_target_f2,
  input  logic             ic_hit_f2,
  input  logic             ic_mb_empty,
  input  logic [CNT_W-1:0] fb_consume,
  input  logic             dma_stall,
  input  logic             ic_write_stall,
  input  logic             halt_req,
  output logic             fetch_req_f1,
  output logic [31:1]      fetch_addr_f1,
  output logic             fetch_req_f2,
  output logic [31:1]      fetch_addr_f2,
  output logic [CNT_W-1:0] fb_occ,
  output logic             halt_ack,
  output logic             pmu_fetch_stall,
  output logic [1:0]       state
);

  localparam int unsigned OFS   = $clog2(FETCH_BYTES);
  localparam int unsigned BLK_W = 32 - OFS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FETCH  = 2'b01,
    S_WFM    = 2'b11,
    S_HALTED = 2'b10
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_reset_pend;
  logic             r_f1_valid, w_f1_valid_nxt;
  logic             r_req_f2;
  logic [31:1]      r_addr_f1, w_addr_f1_nxt;
  logic [31:1]      r_addr_f2;
  logic [31:1]      r_miss_addr, w_miss_addr_nxt;
  logic [31:OFS]    w_blk_nxt;
  logic [31:1]      w_seq_addr;
  logic [CNT_W-1:0] r_fb_occ;
  logic [CNT_W-1:0] w_occ_after, w_occ_sum, w_occ_nxt;
  logic             w_underflow, w_credit_ok;
  logic             w_in_fetch, w_req_f2, w_miss_f2, w_req_f1;
  logic             w_flush_redir, w_flush_idle;

  assign w_in_fetch    = (r_state == S_FETCH);
  assign w_flush_redir = flush_valid & ~flush_noredir;
  assign w_flush_idle  = flush_valid & flush_noredir;
  assign w_req_f2      = r_req_f2 & ~flush_valid;
  assign w_miss_f2     = w_req_f2 & ~ic_hit_f2;

  // Consume beyond occupancy is a protocol error; clamp to empty.
  assign w_underflow = (fb_consume > r_fb_occ);
  assign w_occ_after = w_underflow ? '0 : (r_fb_occ - fb_consume);
  assign w_credit_ok = (w_occ_after < CNT_W'(FB_DEPTH));

  assign w_req_f1 = r_f1_valid & w_in_fetch & ~halt_req & ~dma_stall &
                    ~ic_write_stall & ~flush_valid & ~bp_redirect_f2 &
                    ~w_miss_f2 & w_credit_ok;

  // Issue and miss never coincide, and issue only happens below FB_DEPTH,
  // so the sum stays within CNT_W bits.
  assign w_occ_sum = w_occ_after + CNT_W'(w_req_f1);
  assign w_occ_nxt = (w_miss_f2 && (w_occ_sum == '0)) ? '0 :
                     (w_occ_sum - CNT_W'(w_miss_f2));

  assign w_blk_nxt  = r_addr_f1[31:OFS] + BLK_W'(1);
  assign w_seq_addr = {w_blk_nxt, {(OFS - 1){1'b0}}};

  always_comb begin
    w_state_nxt     = r_state;
    w_f1_valid_nxt  = r_f1_valid;
    w_addr_f1_nxt   = r_addr_f1;
    w_miss_addr_nxt = r_miss_addr;
    if (w_flush_idle) begin
      w_state_nxt    = S_IDLE;
      w_f1_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_flush_redir) begin
            w_state_nxt    = S_FETCH;
            w_f1_valid_nxt = 1'b1;
            w_addr_f1_nxt  = flush_pc;
          end else if (r_reset_pend) begin
            w_state_nxt    = S_FETCH;
            w_f1_valid_nxt = 1'b1;
            w_addr_f1_nxt  = RESET_VEC[31:1];
          end
        end
        S_FETCH: begin
          if (w_flush_redir) begin
            w_addr_f1_nxt = flush_pc;
          end else if (w_miss_f2) begin
            w_state_nxt     = S_WFM;
            w_miss_addr_nxt = r_addr_f2;
          end else begin
            if (bp_redirect_f2) begin
              w_addr_f1_nxt = bp_target_f2;
            end else if (w_req_f1) begin
              w_addr_f1_nxt = w_seq_addr;
            end
            if (halt_req && !w_req_f2) begin
              w_state_nxt = S_HALTED;
            end
          end
        end
        S_WFM: begin
          // A redirect during the fill replaces the replay target.
          if (w_flush_redir) begin
            w_miss_addr_nxt = flush_pc;
          end
          if (ic_mb_empty && !w_miss_f2) begin
            w_state_nxt   = S_FETCH;
            w_addr_f1_nxt = w_miss_addr_nxt;
          end
        end
        S_HALTED: begin
          if (w_flush_redir) begin
            w_addr_f1_nxt = flush_pc;
          end
          if (!halt_req) begin
            w_state_nxt = S_FETCH;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_reset_pend <= 1'b1;
      r_f1_valid   <= 1'b0;
      r_addr_f1    <= '0;
      r_req_f2     <= 1'b0;
      r_addr_f2    <= '0;
      r_miss_addr  <= '0;
      r_fb_occ     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_reset_pend <= 1'b0;
      r_f1_valid   <= w_f1_valid_nxt;
      r_addr_f1    <= w_addr_f1_nxt;
      r_req_f2     <= w_req_f1;
      if (w_req_f1) begin
        r_addr_f2 <= r_addr_f1;
      end
      r_miss_addr  <= w_miss_addr_nxt;
      r_fb_occ     <= flush_valid ? '0 : w_occ_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!w_underflow);
    end
  end

  assign fetch_req_f1    = w_req_f1;
  assign fetch_addr_f1   = r_addr_f1;
  assign fetch_req_f2    = w_req_f2;
  assign fetch_addr_f2   = r_addr_f2;
  assign fb_occ          = r_fb_occ;
  assign halt_ack        = (r_state == S_HALTED);
  assign pmu_fetch_stall = (r_state == S_WFM) |
                           (r_f1_valid & w_in_fetch & ~w_req_f1 & ~flush_valid);
  assign state           = r_state;

endmodule

// File: tb/tb_ifu_fetch_ctl_param.sv
// Bench for ifu_fetch_ctl_param: directed scenarios then random traffic, all
// checked against a byte-address reference model of the fetch pipe.
module tb_ifu_fetch_ctl_param;

  localparam int unsigned FB    = 8;
  localparam int          DEPTH = 4;
  localparam int unsigned CW    = 3;
  localparam logic [31:0] RV    = 32'h8000_0000;
  localparam logic [1:0]  ST_IDLE = 2'b00, ST_FETCH = 2'b01, ST_WFM = 2'b11, ST_HALT = 2'b10;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_valid, flush_noredir, bp_redirect_f2, ic_hit_f2, ic_mb_empty;
  logic          dma_stall, ic_write_stall, halt_req;
  logic [31:1]   flush_pc, bp_target_f2;
  logic [CW-1:0] fb_consume;
  logic          fetch_req_f1, fetch_req_f2, halt_ack, pmu_fetch_stall;
  logic [31:1]   fetch_addr_f1, fetch_addr_f2;
  logic [CW-1:0] fb_occ;
  logic [1:0]    state;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: byte addresses, integer credit count.
  logic [1:0]  m_st;
  logic [31:0] m_f1, m_f2, m_miss;
  bit          m_f1_v, m_f2_v, m_pend;
  int          m_occ;

  ifu_fetch_ctl_param #(
    .FETCH_BYTES(FB),
    .FB_DEPTH   (DEPTH),
    .RESET_VEC  (RV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc),
    .flush_noredir  (flush_noredir),
    .bp_redirect_f2 (bp_redirect_f2),
    .bp_target_f2   (bp_target_f2),
    .ic_hit_f2      (ic_hit_f2),
    .ic_mb_empty    (ic_mb_empty),
    .fb_consume     (fb_consume),
    .dma_stall      (dma_stall),
    .ic_write_stall (ic_write_stall),
    .halt_req       (halt_req),
    .fetch_req_f1   (fetch_req_f1),
    .fetch_addr_f1  (fetch_addr_f1),
    .fetch_req_f2   (fetch_req_f2),
    .fetch_addr_f2  (fetch_addr_f2),
    .fb_occ         (fb_occ),
    .halt_ack       (halt_ack),
    .pmu_fetch_stall(pmu_fetch_stall),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    flush_valid = 1'b0; flush_noredir = 1'b0; flush_pc = '0;
    bp_redirect_f2 = 1'b0; bp_target_f2 = '0; ic_hit_f2 = 1'b1;
    ic_mb_empty = 1'b0; fb_consume = '0; dma_stall = 1'b0;
    ic_write_stall = 1'b0;
  endtask

  // Called at a negedge with inputs applied: check this cycle, then advance.
  task automatic step();
    bit f2, miss, room, issue, stall, redir;
    logic [31:0] seq, fpc, old_f1;
    #1;
    f2    = m_f2_v && !flush_valid;
    miss  = f2 && !ic_hit_f2;
    room  = (m_occ - int'(fb_consume)) < DEPTH;
    issue = m_f1_v && (m_st == ST_FETCH) && !halt_req && !dma_stall && !ic_write_stall &&
            !flush_valid && !bp_redirect_f2 && !miss && room;
    stall = (m_st == ST_WFM) || (m_f1_v && (m_st == ST_FETCH) && !issue && !flush_valid);
    chk("state", state, m_st);
    chk("req_f1", fetch_req_f1, issue);
    if (m_f1_v) chk("addr_f1", {fetch_addr_f1, 1'b0}, m_f1);
    chk("req_f2", fetch_req_f2, f2);
    if (f2) chk("addr_f2", {fetch_addr_f2, 1'b0}, m_f2);
    chk("fb_occ", fb_occ, m_occ);
    chk("halt_ack", halt_ack, m_st == ST_HALT);
    chk("pmu_stall", pmu_fetch_stall, stall);

    seq    = ((m_f1 / FB) + 1) * FB;
    fpc    = {flush_pc, 1'b0};
    redir  = flush_valid && !flush_noredir;
    old_f1 = m_f1;
    if (flush_valid && flush_noredir) begin
      m_st = ST_IDLE; m_f1_v = 0;
    end else begin
      case (m_st)
        ST_IDLE: begin
          if (redir) begin m_st = ST_FETCH; m_f1_v = 1; m_f1 = fpc; end
          else if (m_pend) begin m_st = ST_FETCH; m_f1_v = 1; m_f1 = RV; end
        end
        ST_FETCH: begin
          if (redir) m_f1 = fpc;
          else if (miss) begin m_st = ST_WFM; m_miss = m_f2; end
          else begin
            if (bp_redirect_f2) m_f1 = {bp_target_f2, 1'b0};
            else if (issue) m_f1 = seq;
            if (halt_req && !f2) m_st = ST_HALT;
          end
        end
        ST_WFM: begin
          if (redir) m_miss = fpc;
          if (ic_mb_empty) begin m_st = ST_FETCH; m_f1 = m_miss; end
        end
        default: begin
          if (redir) m_f1 = fpc;
          if (!halt_req) m_st = ST_FETCH;
        end
      endcase
    end
    m_pend = 0;
    m_occ  = flush_valid ? 0 : m_occ + int'(issue) - int'(fb_consume) - int'(miss);
    m_f2_v = issue;
    if (issue) m_f2 = old_f1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; halt_req = 1'b0;
    quiet();
    m_st = ST_IDLE; m_f1 = '0; m_f2 = '0; m_miss = '0;
    m_f1_v = 0; m_f2_v = 0; m_pend = 1; m_occ = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state, ST_IDLE);
    chk("rst_req_f1", fetch_req_f1, 0);
    chk("rst_req_f2", fetch_req_f2, 0);
    chk("rst_occ", fb_occ, 0);
    chk("rst_ack", halt_ack, 0);
    chk("rst_pmu", pmu_fetch_stall, 0);
    chk("rst_addr", fetch_addr_f1, 0);

    // Reset vector and credit fill
    rst = 1'b0;
    step();
    chk("rv_req", fetch_req_f1, 1);
    chk("rv_addr", fetch_addr_f1, 31'h4000_0000);
    step();
    chk("rv_seq", fetch_addr_f1, 31'h4000_0004);
    repeat (4) step();
    chk("fill_occ", fb_occ, 4);
    chk("fill_req", fetch_req_f1, 0);
    chk("fill_pmu", pmu_fetch_stall, 1);
    fb_consume = 3'd2;
    #1 chk("consume_resume", fetch_req_f1, 1);
    step();
    fb_consume = '0;

    // Miss and replay
    flush_valid = 1'b1; flush_pc = 31'h800;
    step();
    flush_valid = 1'b0;
    step();
    ic_hit_f2 = 1'b0;
    step();
    ic_hit_f2 = 1'b1;
    chk("miss_state", state, ST_WFM);
    chk("miss_occ", fb_occ, 0);
    repeat (2) step();
    ic_mb_empty = 1'b1;
    step();
    ic_mb_empty = 1'b0;
    chk("replay_req", fetch_req_f1, 1);
    chk("replay_addr", fetch_addr_f1, 31'h800);

    // Flush beats BTB redirect
    step();
    flush_valid = 1'b1; flush_pc = 31'h1800;
    bp_redirect_f2 = 1'b1; bp_target_f2 = 31'h1000;
    step();
    flush_valid = 1'b0; bp_redirect_f2 = 1'b0;
    chk("fvb_addr", fetch_addr_f1, 31'h1800);
    chk("fvb_occ", fb_occ, 0);
    chk("fvb_req_f2", fetch_req_f2, 0);

    // Halt with F1 pending and F2 valid, then resume
    repeat (2) step();
    halt_req = 1'b1;
    repeat (2) step();
    chk("halt_ack", halt_ack, 1);
    step();
    halt_req = 1'b0;
    step();
    chk("resume_req", fetch_req_f1, 1);
    chk("resume_addr", {fetch_addr_f1, 1'b0}, m_f1);
    chk("resume_held", fetch_addr_f1, 31'h1808);
    halt_req = 1'b1;
    repeat (3) step();
    flush_valid = 1'b1; flush_noredir = 1'b1;
    step();
    quiet();
    halt_req = 1'b0;
    chk("noredir_idle", state, ST_IDLE);

    // Address wrap at the top of the space
    flush_valid = 1'b1; flush_pc = 31'h7FFF_FFFC;
    step();
    flush_valid = 1'b0;
    chk("wrap_top", fetch_addr_f1, 31'h7FFF_FFFC);
    step();
    chk("wrap_zero", fetch_addr_f1, 31'h0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int mx;
      flush_valid    = ($urandom_range(0, 99) < 4);
      flush_noredir  = ($urandom_range(0, 99) < 30);
      flush_pc       = 31'($urandom());
      bp_redirect_f2 = ($urandom_range(0, 99) < 10);
      bp_target_f2   = 31'($urandom());
      ic_hit_f2      = ($urandom_range(0, 99) < 80);
      ic_mb_empty    = ($urandom_range(0, 99) < 30);
      dma_stall      = ($urandom_range(0, 99) < 10);
      ic_write_stall = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 4) halt_req = ~halt_req;
      mx = m_occ - int'(m_f2_v);
      fb_consume = CW'($urandom_range(0, mx));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
